// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants, arctangent table and FSM state type
package cordic_pkg;
  localparam logic signed [31:0] K_Q31 = 32'sd1304065748;
  localparam logic signed [31:0] DEG90 = 32'sd90000000;
  localparam logic signed [31:0] DEG180 = 32'sd180000000;
  localparam logic signed [31:0] ATAN_TABLE [0:15] = '{
    32'sd45000000, 32'sd26565051, 32'sd14036243, 32'sd7125016,
    32'sd3576334, 32'sd1789911, 32'sd895174, 32'sd447614,
    32'sd223811, 32'sd111906, 32'sd55953, 32'sd27976,
    32'sd13988, 32'sd6994, 32'sd3497, 32'sd1749};
  typedef enum logic [1:0] {IDLE, SCALE, ITER, DONE} state_t;
endpackage

// File: rtl/cordic_micro_rotation.sv
// cordic_micro_rotation: one combinational CORDIC rotation-mode step
module cordic_micro_rotation
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [31:0]      z_i,
  input  logic        [3:0]       i_i,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [31:0]      z_o
);
  logic signed [WIDTH-1:0] xs, ys;
  logic signed [31:0] a;
  logic pos;
  always_comb begin
    pos = ~z_i[31];
    xs = x_i >>> i_i;
    ys = y_i >>> i_i;
    a = ATAN_TABLE[i_i];
    x_o = pos ? x_i - ys : x_i + ys;
    y_o = pos ? y_i + xs : y_i - xs;
    z_o = pos ? z_i - a : z_i + a;
  end
endmodule

// File: rtl/cordic_rotation_iterative.sv
// cordic_rotation_iterative: polar-to-Cartesian iterative CORDIC, one
// micro-rotation per clock with quadrant pre-rotation and gain compensation
module cordic_rotation_iterative
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERATIONS = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [WIDTH-1:0] magnitude_i,
  input  logic signed [31:0]      angle_in_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [WIDTH-1:0] x_out_o,
  output logic signed [WIDTH-1:0] y_out_o,
  output logic                    range_err_o
);
  typedef logic signed [2*WIDTH-1:0] wide_t;
  state_t state_q, state_d;
  logic signed [WIDTH-1:0] mag_q, mag_d, x_q, x_d, y_q, y_d, xo_q, xo_d, yo_q, yo_d;
  logic signed [31:0] ang_q, ang_d, z_q, z_d;
  logic [3:0] i_q, i_d;
  logic err_q, err_d, ro_q, ro_d;
  logic signed [WIDTH-1:0] xn, yn, m;
  logic signed [31:0] zn;
  wide_t prod;
  logic oor, hi, lo;

  cordic_micro_rotation #(.WIDTH(WIDTH)) u_rot (
    .x_i(x_q), .y_i(y_q), .z_i(z_q), .i_i(i_q),
    .x_o(xn), .y_o(yn), .z_o(zn)
  );

  // Gain pre-compensation, floored Q31 product
  assign prod = wide_t'(mag_q) * wide_t'(K_Q31);
  assign m = WIDTH'(prod >>> 31);
  assign oor = (ang_q > DEG180) || (ang_q < -DEG180);
  assign hi = ang_q > DEG90;
  assign lo = ang_q < -DEG90;
  assign in_ready_o = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign x_out_o = xo_q;
  assign y_out_o = yo_q;
  assign range_err_o = ro_q;

  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    ang_d = ang_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    i_d = i_q;
    err_d = err_q;
    xo_d = xo_q;
    yo_d = yo_q;
    ro_d = ro_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        state_d = SCALE;
        mag_d = magnitude_i;
        ang_d = angle_in_i;
      end
      SCALE: begin
        state_d = ITER;
        i_d = '0;
        err_d = oor;
        x_d = (oor || hi || lo) ? '0 : m;
        y_d = oor ? '0 : hi ? m : lo ? -m : '0;
        z_d = oor ? '0 : hi ? ang_q - DEG90 : lo ? ang_q + DEG90 : ang_q;
      end
      ITER: begin
        x_d = xn;
        y_d = yn;
        z_d = zn;
        i_d = i_q + 4'd1;
        if (i_q == 4'(ITERATIONS - 1)) begin
          state_d = DONE;
          xo_d = xn;
          yo_d = yn;
          ro_d = err_q;
        end
      end
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      mag_q <= '0;
      ang_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      i_q <= '0;
      err_q <= 1'b0;
      xo_q <= '0;
      yo_q <= '0;
      ro_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      ang_q <= ang_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
      err_q <= err_d;
      xo_q <= xo_d;
      yo_q <= yo_d;
      ro_q <= ro_d;
    end
  end
endmodule

// File: tb/tb_cordic_rotation_iterative.sv
// tb_cordic_rotation_iterative: directed vectors against a trigonometric reference model
module tb_cordic_rotation_iterative;
  localparam int ITER = 16;
  localparam real PI = 3.14159265358979323846;
  logic clk = 0, rst = 1, iv = 0, ordy = 1;
  logic signed [31:0] mag = 0, ang = 0;
  logic in_ready, out_valid, err;
  logic signed [31:0] x, y;
  int tests = 0, fails = 0, cyc = 0;
  bit chk_en = 0;
  typedef struct {real ex; real ey; bit err; int acc; bit seen;} exp_t;
  exp_t q[$];
  logic signed [31:0] px, py, rx, ry;
  real mx, my, dx, dy;
  bit me, de, ok;

  cordic_rotation_iterative #(.WIDTH(32), .ITERATIONS(ITER)) dut (
    .clock_i(clk), .reset_i(rst), .in_valid_i(iv), .in_ready_o(in_ready),
    .magnitude_i(mag), .angle_in_i(ang), .out_valid_o(out_valid),
    .out_ready_i(ordy), .x_out_o(x), .y_out_o(y), .range_err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit c, input longint got, input longint want);
    tests++;
    if (!c) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, got, want);
    end
  endtask

  function automatic bit near(input longint g, input real e);
    return ($itor(g) - e <= 64.0) && ($itor(g) - e >= -64.0);
  endfunction

  function automatic void model(input int m, input int a, output real ox, output real oy, output bit oe);
    oe = (a > 180000000) || (a < -180000000);
    ox = oe ? 0.0 : $itor(m) * $cos($itor(a) * PI / 180.0e6);
    oy = oe ? 0.0 : $itor(m) * $sin($itor(a) * PI / 180.0e6);
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("in_ready", in_ready == (q.size() == 0), in_ready, q.size() == 0);
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_valid", 0, 1, 0);
      else begin
        if (!q[0].seen) begin
          chk("latency", cyc - q[0].acc == ITER + 1, cyc - q[0].acc, ITER + 1);
          q[0].seen = 1;
        end else begin
          chk("hold_x", x == px, x, px);
          chk("hold_y", y == py, y, py);
        end
        chk("model_err", err == q[0].err, err, q[0].err);
        if (q[0].err) begin
          chk("model_err_x", x == 0, x, 0);
          chk("model_err_y", y == 0, y, 0);
        end else begin
          chk("model_x", near(x, q[0].ex), x, $rtoi(q[0].ex));
          chk("model_y", near(y, q[0].ey), y, $rtoi(q[0].ey));
        end
        if (ordy) void'(q.pop_front());
      end
      px = x;
      py = y;
    end
    if (rst) q.delete();
    else if (iv && in_ready) begin
      model(mag, ang, mx, my, me);
      q.push_back('{ex: mx, ey: my, err: me, acc: cyc + 1, seen: 0});
    end
  end

  task automatic send(input int m, input int a);
    mag = m;
    ang = a;
    iv = 1;
    for (int n = 0; n < 100; n++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        iv = 0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 0, 0, 1);
    iv = 0;
  endtask

  task automatic wait_valid(output bit v);
    v = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid) begin
        v = 1;
        return;
      end
    end
    chk("valid_timeout", 0, 0, 1);
  endtask

  task automatic run(input string nm, input int m, input int a, input int lx, input int ly, input bit le);
    bit v;
    send(m, a);
    wait_valid(v);
    if (v) begin
      chk({nm, "_x"}, le ? x == lx : near(x, lx), x, lx);
      chk({nm, "_y"}, le ? y == ly : near(y, ly), y, ly);
      chk({nm, "_err"}, err == le, err, le);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_ready", in_ready == 1, in_ready, 1);
    chk("rst_valid", out_valid == 0, out_valid, 0);
    chk("rst_x", x == 0, x, 0);
    chk("rst_y", y == 0, y, 0);
    chk("rst_err", err == 0, err, 0);
    model(1000000, 0, dx, dy, de);
    chk("pin0_x", near($rtoi(dx), 1000000.0), $rtoi(dx), 1000000);
    model(1000000, -45000000, dx, dy, de);
    chk("pin45_x", $rtoi(dx + 0.5) == 707107, $rtoi(dx + 0.5), 707107);
    chk("pin45_y", $rtoi(dy - 0.5) == -707107, $rtoi(dy - 0.5), -707107);
    model(1000000, 200000000, dx, dy, de);
    chk("pin_err", de == 1, de, 1);
    @(posedge clk); #1;
    run("a0", 1000000, 0, 1000000, 0, 0);
    run("am45", 1000000, -45000000, 707107, -707107, 0);
    run("a90", 1000000, 90000000, 0, 1000000, 0);
    run("a180", 1000000, 180000000, -1000000, 0, 0);
    run("am135", 1000000, -135000000, -707107, -707107, 0);
    run("oor", 1000000, 200000000, 0, 0, 1);
    run("a30", 1000000, 30000000, 866025, 500000, 0);
    run("am180", 1000000, -180000000, -1000000, 0, 0);
    run("oorneg", 1000000, -180000001, 0, 0, 1);
    run("neg120", -500000, 120000000, 250000, -433013, 0);
    ordy = 0;
    send(1000000, 60000000);
    wait_valid(ok);
    rx = x;
    ry = y;
    chk("bp_x", near(rx, 500000.0), rx, 500000);
    chk("bp_y", near(ry, 866025.0), ry, 866025);
    @(posedge clk); #1;
    mag = 1000000;
    ang = -60000000;
    iv = 1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", out_valid == 1, out_valid, 1);
      chk("bp_hold_x", x == rx, x, rx);
      chk("bp_hold_y", y == ry, y, ry);
      chk("bp_ready", in_ready == 0, in_ready, 0);
    end
    @(posedge clk); #1;
    ordy = 1;
    @(posedge clk); #1;
    chk("bp_idle_ready", in_ready == 1, in_ready, 1);
    chk("bp_idle_valid", out_valid == 0, out_valid, 0);
    @(posedge clk); #1;
    iv = 0;
    chk("bp_accepted", in_ready == 0, in_ready, 0);
    wait_valid(ok);
    chk("bp2_x", near(x, 500000.0), x, 500000);
    chk("bp2_y", near(y, -866025.0), y, -866025);
    @(posedge clk); #1;
    send(1000000, 45000000);
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_ready", in_ready == 1, in_ready, 1);
    chk("mid_rst_valid", out_valid == 0, out_valid, 0);
    chk("mid_rst_x", x == 0, x, 0);
    chk("mid_rst_y", y == 0, y, 0);
    chk("mid_rst_err", err == 0, err, 0);
    repeat (25) @(negedge clk);
    @(posedge clk); #1;
    run("after_rst", 1000000, 45000000, 707107, 707107, 0);
    repeat (3) @(posedge clk);
    chk("drained", q.size() == 0, q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
